// File: rtl/i2s_playback_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2s_playback_tx
// Description : Serialises one stereo pair of signed samples per 256-mclk
//               frame into I2S playback signals (bclk, pblrc, pbdat) and
//               pulses sample_ack while the pair is being captured.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_playback_tx #(
  parameter int SAMPLE_BITS   = 16,
  parameter int MCLK_PER_BCLK = 4,
  parameter int SLOT_BITS     = 32
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          en,
  input  logic signed [SAMPLE_BITS-1:0] sample_l,
  input  logic signed [SAMPLE_BITS-1:0] sample_r,
  output logic                          sample_ack,
  output logic                          bclk,
  output logic                          pblrc,
  output logic                          pbdat
);

  // Frame counter splits into {bit index, mclk phase within the bit}.
  localparam int DIV_W = $clog2(MCLK_PER_BCLK);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int CNT_W = DIV_W + BIT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shift_l_q, shift_l_d;
  logic [SAMPLE_BITS-1:0] shift_r_q, shift_r_d;
  logic                   sample_ack_q, sample_ack_d;
  logic                   bclk_q, bclk_d;
  logic                   pblrc_q, pblrc_d;
  logic                   pbdat_q, pbdat_d;
  int                     bit_idx;
  logic                   bit_edge;

  // Next-state, capture and output decode; outputs are decoded from the
  // next count so the registered value lines up with the current count.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_l_d    = shift_l_q;
    shift_r_d    = shift_r_q;
    sample_ack_d = 1'b0;
    bclk_d       = 1'b0;
    pblrc_d      = 1'b0;
    pbdat_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (!en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Samples are latched on the edge that leaves count 0.
    if (state_q == RUN && cnt_q == '0) begin
      shift_l_d = sample_l;
      shift_r_d = sample_r;
    end

    bit_idx  = int'(cnt_d[CNT_W-1:DIV_W]);
    bit_edge = (cnt_d[DIV_W-1:0] == '0);

    if (state_d == RUN) begin
      sample_ack_d = (cnt_d == '0);
      bclk_d       = cnt_d[DIV_W-1];
      pblrc_d      = cnt_d[CNT_W-1];
      pbdat_d      = pbdat_q;
      // Data moves only on bclk falling edges; bit 0 of each slot is the
      // one-bclk I2S delay, and unused slot bits are padded with zero.
      if (bit_edge) begin
        pbdat_d = 1'b0;
        if (bit_idx >= 1 && bit_idx <= SAMPLE_BITS) begin
          pbdat_d   = shift_l_q[SAMPLE_BITS-1];
          shift_l_d = {shift_l_q[SAMPLE_BITS-2:0], 1'b0};
        end else if (bit_idx >= SLOT_BITS + 1 && bit_idx <= SLOT_BITS + SAMPLE_BITS) begin
          pbdat_d   = shift_r_q[SAMPLE_BITS-1];
          shift_r_d = {shift_r_q[SAMPLE_BITS-2:0], 1'b0};
        end
      end
    end
  end

  // State, counter, shift registers and registered outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_l_q    <= '0;
      shift_r_q    <= '0;
      sample_ack_q <= 1'b0;
      bclk_q       <= 1'b0;
      pblrc_q      <= 1'b0;
      pbdat_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
      sample_ack_q <= sample_ack_d;
      bclk_q       <= bclk_d;
      pblrc_q      <= pblrc_d;
      pbdat_q      <= pbdat_d;
    end
  end

  assign sample_ack = sample_ack_q;
  assign bclk       = bclk_q;
  assign pblrc      = pblrc_q;
  assign pbdat      = pbdat_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_playback_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2s_playback_tx
// Description : Self-checking bench for i2s_playback_tx: frame table driver,
//               expected-word scoreboard and frame-relative output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_playback_tx;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_ack, bclk, pblrc, pbdat;

  i2s_playback_tx #(
    .SAMPLE_BITS  (16),
    .MCLK_PER_BCLK(4),
    .SLOT_BITS    (32)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .en        (en),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .sample_ack(sample_ack),
    .bclk      (bclk),
    .pblrc     (pblrc),
    .pbdat     (pbdat)
  );

  // Free-running master clock.
  always #5 mclk = ~mclk;

  // One frame record: inputs for the frame, en level held from cnt 10, and
  // the 64 slot bits expected on pbdat (bit 63 = first bclk of the frame).
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        en_keep;
    logic [63:0] exp_word;
  } vec_t;

  vec_t        tbl[7];
  logic [63:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  int          mcnt = 0;
  bit          active = 1'b0;
  logic [63:0] word = '0;
  int          frame_err = 0;
  logic        prev_pbdat = 1'b0;
  int          idle_err = 0;
  int          ack_cnt = 0;
  int          ack_bad = 0;
  int          frames_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: tracks position within the frame from sample_ack, checks bclk,
  // pblrc and pbdat stability, collects pbdat at bclk rising edges and
  // scores each finished frame against the scoreboard queue.
  always @(negedge mclk) begin
    if (rst) begin
      active = 1'b0;
    end else begin
      if (sample_ack) begin
        ack_cnt++;
        if (active && mcnt != 255) ack_bad++;
        mcnt      = 0;
        active    = 1'b1;
        word      = '0;
        frame_err = 0;
      end else if (active) begin
        mcnt++;
        if (mcnt > 255) active = 1'b0;
      end
      if (active) begin
        if (bclk !== mcnt[1]) frame_err++;
        if (pblrc !== mcnt[7]) frame_err++;
        if (mcnt[1:0] != 2'd0 && pbdat !== prev_pbdat) frame_err++;
        if (mcnt[1:0] == 2'd2) word[63 - (mcnt / 4)] = pbdat;
        if (mcnt == 255) begin
          frames_done++;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 64'(frames_done), 64'(frames_done - 1));
          end else begin
            check("frame_word", word, exp_q.pop_front());
            check("frame_timing_errs", 64'(frame_err), 64'd0);
          end
        end
      end else if (bclk || pblrc || pbdat) begin
        idle_err++;
      end
      prev_pbdat = pbdat;
    end
  end

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (!sample_ack && n < 600);
    if (!sample_ack) check("ack_timeout", 64'(sample_ack), 64'd1);
  endtask

  // Stimulus: frame table, then en-drop, async reset and idle sequences.
  initial begin
    int n;
    int since;
    int idle_base;
    int ack_base;

    tbl[0] = '{16'h8001, 16'h7FFE, 1'b1, 64'h40008000_3FFF0000};
    tbl[1] = '{16'h1234, 16'h7FFE, 1'b1, 64'h091A0000_3FFF0000};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 64'h7FFF8000_00000000};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 64'h00000000_00000000};
    tbl[4] = '{16'h0001, 16'h0001, 1'b1, 64'h00008000_00008000};
    tbl[5] = '{16'h0002, 16'h0002, 1'b1, 64'h00010000_00010000};
    tbl[6] = '{16'h0003, 16'h0003, 1'b0, 64'h00018000_00018000};

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge mclk);
    check("reset_outputs", 64'({sample_ack, bclk, pblrc, pbdat}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge mclk);

    // Back-to-back frames; next inputs are applied at cnt 50 of the frame
    // in flight, which must not disturb it.
    since = 0;
    for (int i = 0; i < 7; i++) begin
      sample_l = tbl[i].l;
      sample_r = tbl[i].r;
      en       = 1'b1;
      wait_ack(n);
      since += n;
      if (i > 0) check("ack_spacing", 64'(since), 64'd256);
      exp_q.push_back(tbl[i].exp_word);
      repeat (10) @(negedge mclk);
      en = tbl[i].en_keep;
      repeat (40) @(negedge mclk);
      since = 50;
    end

    // en was dropped at cnt 10 of the last frame: it completes, then IDLE.
    repeat (462) @(negedge mclk);
    check("ack_count_after_en_drop", 64'(ack_cnt), 64'd7);
    check("idle_after_en_drop", 64'(idle_err), 64'd0);
    check("frames_done", 64'(frames_done), 64'd7);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a right-slot bit.
    sample_l = 16'hFFFF;
    sample_r = 16'hFFFF;
    en       = 1'b1;
    wait_ack(n);
    repeat (134) @(negedge mclk);
    check("pre_reset_outputs", 64'({bclk, pblrc, pbdat}), 64'h7);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'({sample_ack, bclk, pblrc, pbdat}), 64'd0);
    en = 1'b0;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    idle_base = idle_err;
    ack_base  = ack_cnt;
    repeat (512) @(negedge mclk);
    check("idle_after_reset", 64'(idle_err - idle_base), 64'd0);
    check("ack_after_reset", 64'(ack_cnt - ack_base), 64'd0);
    check("ack_width", 64'(ack_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
